// File: rtl/ahb_lsu_master_pkg.sv
// Shared AHB-Lite encodings and LSU master state type.
// The bus encodings are also reused by the fetch-side master.
package ahb_lsu_master_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HBURST encodings (only SINGLE is issued by the LSU)
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  // HSIZE encodings
  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // HPROT bit positions
  localparam int HPROT_DATA_BIT       = 0;
  localparam int HPROT_PRIV_BIT       = 1;
  localparam int HPROT_BUFFERABLE_BIT = 2;
  localparam int HPROT_CACHEABLE_BIT  = 3;

  // LSU master transfer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR2 = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_e;

  // Maps an LSU size code onto the HSIZE field
  function automatic logic [2:0] hsize_of(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/ahb_lsu_master_lane_align.sv
// Byte-lane steering for the LSU master: store data replication across
// all lanes and load data extraction with sign/zero extension.
module ahb_lane_align #(
  parameter int DATA_W = 32,
  parameter int LANE_W = $clog2(DATA_W / 8)
) (
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [LANE_W-1:0] addr_lo_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [63:0] wide_w;
  logic [63:0] rep_w;
  logic [63:0] wide_r;
  logic [63:0] lane_r;
  logic [63:0] ext_r;
  logic        sign_fill;

  // Work at 64 bits internally so both legal widths share one datapath
  always_comb begin
    wide_w = '0;
    wide_w[DATA_W-1:0] = wdata_i;
    case (size_i)
      2'd0:    rep_w = {8{wide_w[7:0]}};
      2'd1:    rep_w = {4{wide_w[15:0]}};
      2'd2:    rep_w = {2{wide_w[31:0]}};
      default: rep_w = wide_w;
    endcase
    wdata_o = rep_w[DATA_W-1:0];

    wide_r = '0;
    wide_r[DATA_W-1:0] = rdata_i;
    lane_r = wide_r >> {addr_lo_i, 3'b000};
    sign_fill = 1'b0;
    case (size_i)
      2'd0: begin
        sign_fill = ~unsigned_i & lane_r[7];
        ext_r = {{56{sign_fill}}, lane_r[7:0]};
      end
      2'd1: begin
        sign_fill = ~unsigned_i & lane_r[15];
        ext_r = {{48{sign_fill}}, lane_r[15:0]};
      end
      2'd2: begin
        sign_fill = ~unsigned_i & lane_r[31];
        ext_r = {{32{sign_fill}}, lane_r[31:0]};
      end
      default: ext_r = lane_r;
    endcase
    rdata_o = ext_r[DATA_W-1:0];
  end

endmodule

// File: rtl/ahb_lsu_master.sv
// AHB-Lite master for the LSU: one outstanding single transfer, byte-lane
// steering, two-cycle ERROR handling and misalignment trapping.
module ahb_lsu_master
  import ahb_lsu_master_pkg::*;
#(
  parameter int         ADDR_W     = 32,
  parameter int         DATA_W     = 32,
  parameter logic [3:0] HPROT_DATA = 4'b0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic              stallreq_o,
  output logic              hsel_o,
  output logic [1:0]        htrans_o,
  output logic [ADDR_W-1:0] haddr_o,
  output logic              hwrite_o,
  output logic [2:0]        hsize_o,
  output logic [2:0]        hburst_o,
  output logic [3:0]        hprot_o,
  output logic              hmastlock_o,
  output logic [DATA_W-1:0] hwdata_o,
  input  logic              hready_i,
  input  logic              hresp_i,
  input  logic [DATA_W-1:0] hrdata_i
);

  localparam int         LANE_W   = $clog2(DATA_W / 8);
  localparam logic [1:0] MAX_SIZE = 2'(LANE_W);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] align_mask;
  logic              req_illegal;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] rdata_ext;
  logic              in_addr;
  logic              in_data;

  ahb_lane_align #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_lane_align (
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .addr_lo_i  (addr_q[LANE_W-1:0]),
    .wdata_i    (wdata_q),
    .rdata_i    (hrdata_i),
    .wdata_o    (wdata_rep),
    .rdata_o    (rdata_ext)
  );

  // Request legality: size must fit the bus and the address must be aligned
  always_comb begin
    align_mask  = (ADDR_W'(1) << req_size_i) - ADDR_W'(1);
    req_illegal = (req_size_i > MAX_SIZE) || ((req_addr_i & align_mask) != '0);
  end

  // State and transfer registers; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: accept, address phase, data phase, ERROR tail, response
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          rdata_d = '0;
          if (req_illegal) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d      = 1'b0;
            addr_d     = req_addr_i;
            we_d       = req_we_i;
            size_d     = req_size_i;
            unsigned_d = req_unsigned_i;
            wdata_d    = req_wdata_i;
            state_d    = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (hready_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (hready_i) begin
          state_d = ST_RESP;
          if (hresp_i == HRESP_ERROR) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            err_d   = 1'b0;
            rdata_d = we_q ? '0 : rdata_ext;
          end
        end else if (hresp_i == HRESP_ERROR) begin
          state_d = ST_ERR2;
        end
      end
      ST_ERR2: begin
        if (hready_i) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_addr = (state_q == ST_ADDR);
  assign in_data = (state_q == ST_DATA) || (state_q == ST_ERR2);

  assign hsel_o      = in_addr;
  assign htrans_o    = in_addr ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr_o     = in_addr ? addr_q : '0;
  assign hwrite_o    = in_addr & we_q;
  assign hsize_o     = in_addr ? hsize_of(size_q) : HSIZE_BYTE;
  assign hburst_o    = HBURST_SINGLE;
  assign hprot_o     = in_addr ? HPROT_DATA : 4'b0000;
  assign hmastlock_o = 1'b0;
  assign hwdata_o    = (in_data && we_q) ? wdata_rep : '0;

  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_rdata_o = resp_valid_o ? rdata_q : '0;
  assign resp_err_o   = resp_valid_o & err_q;

  assign req_ready_o = rst_n & req_valid_i & (state_q == ST_IDLE);
  assign stallreq_o  = rst_n & req_valid_i & ~resp_valid_o;

endmodule
